// File: rtl/rca_seq_adder_ctrl.sv
// Low-area WIDTH-bit adder: one 4-bit ripple slice reused over WIDTH/4 cycles, LSB nibble first.
// Optional macro RCA_SEQ_OVF_DETECT_EN adds a registered signed-overflow output (ovf).

module ripple_carry_adder_4 (
   output logic [3:0] sum,
   output logic       cout,
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   input  logic       cin
);
   logic [4:0] c;

   always_comb begin
      c[0] = cin;
      sum  = '0;
      for (int i = 0; i < 4; i++) begin
         sum[i]  = in1[i] ^ in2[i] ^ c[i];
         c[i+1]  = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
      end
      cout = c[4];
   end
endmodule

module rca_seq_adder_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef RCA_SEQ_OVF_DETECT_EN
   ,
   output logic             ovf
`endif
);
   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic [3:0]        add_sum;
   logic              add_cout;
   logic              last;
`ifdef RCA_SEQ_OVF_DETECT_EN
   logic              ovf_q, ovf_d;
`endif

   ripple_carry_adder_4 u_slice (
      .sum  (add_sum),
      .cout (add_cout),
      .in1  (opa_q[4*idx_q +: 4]),
      .in2  (opb_q[4*idx_q +: 4]),
      .cin  (carry_q)
   );

   assign last = (idx_q == IDXW'(NSLICE - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_DETECT_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            // DONE accepts a new start just like IDLE so back-to-back adds have no bubble
            if (start) begin
               opa_d   = in1;
               opb_d   = in2;
               carry_d = cin;
               idx_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            sum_d[4*idx_q +: 4] = add_sum;
            carry_d             = add_cout;
            if (last) begin
               cout_d  = add_cout;
               idx_d   = '0;
               state_d = StDone;
`ifdef RCA_SEQ_OVF_DETECT_EN
               ovf_d   = (opa_q[WIDTH-1] ~^ opb_q[WIDTH-1]) & (add_sum[3] ^ opa_q[WIDTH-1]);
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_DETECT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_DETECT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign ready = (state_q == StIdle) || (state_q == StDone);
   assign busy  = (state_q == StRun);
   assign done  = (state_q == StDone);
   assign sum   = sum_q;
   assign cout  = cout_q;
`ifdef RCA_SEQ_OVF_DETECT_EN
   assign ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Self-checking bench for rca_seq_adder_ctrl (WIDTH=16) against an arithmetic reference model.

module tb_rca_seq_adder_ctrl;
   localparam int W      = 16;
   localparam int NSLICE = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] in1, in2;
   logic         cin;
   logic         ready, busy, done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   rca_seq_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef RCA_SEQ_OVF_DETECT_EN
      ,
      .ovf   (ovf)
`endif
   );

`ifndef RCA_SEQ_OVF_DETECT_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: unsigned W+1-bit sum and signed-range overflow
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      ref_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int s;
      s = int'($signed(a)) + int'($signed(b)) + int'(c);
      ref_ovf = (s > 32767) || (s < -32768);
   endfunction

   // Issues one add from a ready state; returns the result and cycles from accept edge to done
   task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit scramble, output logic [W-1:0] s, output logic co,
                         output logic o, output int lat, output int busy_cnt);
      in1 = a; in2 = b; cin = c; start = 1'b1;
      tick();
      start = 1'b0;
      if (scramble) begin
         in1 = 16'($urandom); in2 = 16'($urandom); cin = 1'($urandom);
      end
      lat = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      s = sum; co = cout; o = ovf;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
      #2;
      total++;
      if ({ready, busy, done, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset: got rdy=%b busy=%b done=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
                  ready, busy, done, sum, cout, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [W-1:0] av[3] = '{16'h0001, 16'hFFFF, 16'hABCD};
      logic [W-1:0] bv[3] = '{16'h0000, 16'h0001, 16'h1234};
      logic         cv[3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] s; logic co, o; int lat, bc;
      for (int i = 0; i < 3; i++) begin
         do_add(av[i], bv[i], cv[i], (i == 2), s, co, o, lat, bc);
         total++;
         if (lat !== NSLICE || bc !== NSLICE) begin
            bad++;
            $display("FAIL directed%0d latency: got lat=%0d busy=%0d want %0d/%0d",
                     i, lat, bc, NSLICE, NSLICE);
         end
         total++;
         if ({co, s} !== ref_sum(av[i], bv[i], cv[i])) begin
            bad++;
            $display("FAIL directed%0d result: got %b_%h want %h", i, co, s,
                     ref_sum(av[i], bv[i], cv[i]));
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, s; logic c, co, o; int lat, bc;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         do_add(a, b, c, 1'b1, s, co, o, lat, bc);
         total++;
         if ({co, s} !== ref_sum(a, b, c) || lat !== NSLICE) begin
            bad++;
            $display("FAIL random%0d: got %b_%h lat=%0d want %h lat=%0d", i, co, s, lat,
                     ref_sum(a, b, c), NSLICE);
         end
`ifdef RCA_SEQ_OVF_DETECT_EN
         total++;
         if (o !== ref_ovf(a, b, c)) begin
            bad++;
            $display("FAIL random%0d ovf: got %b want %b", i, o, ref_ovf(a, b, c));
         end
`endif
         tick();
         total++;
         if ({cout, sum} !== ref_sum(a, b, c) || ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL random%0d hold: got %b_%h rdy=%b done=%b want %h 1 0", i, cout, sum,
                     ready, done, ref_sum(a, b, c));
         end
      end
   endtask

   task automatic test_back_to_back();
      int gap;
      in1 = 16'h0F0F; in2 = 16'h00F1; cin = 1'b0; start = 1'b1;
      tick();
      gap = 0;
      while (done !== 1'b1 && gap < 20) begin
         tick(); gap++;
      end
      total++;
      if ({cout, sum} !== ref_sum(16'h0F0F, 16'h00F1, 1'b0) || ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b first: got %b_%h rdy=%b want %h 1", cout, sum, ready,
                  ref_sum(16'h0F0F, 16'h00F1, 1'b0));
      end
      in1 = 16'h8000; in2 = 16'h8000;
      tick();
      gap = 1;
      while (done !== 1'b1 && gap < 20) begin
         tick(); gap++;
      end
      start = 1'b0;
      total++;
      if (gap !== NSLICE + 1) begin
         bad++;
         $display("FAIL b2b spacing: got %0d want %0d", gap, NSLICE + 1);
      end
      total++;
      if ({cout, sum} !== ref_sum(16'h8000, 16'h8000, 1'b0)) begin
         bad++;
         $display("FAIL b2b second: got %b_%h want %h", cout, sum,
                  ref_sum(16'h8000, 16'h8000, 1'b0));
      end
`ifdef RCA_SEQ_OVF_DETECT_EN
      total++;
      if (ovf !== 1'b1) begin
         bad++;
         $display("FAIL b2b ovf: got %b want 1", ovf);
      end
`endif
      tick();
   endtask

   task automatic test_ignore();
      int lat;
      in1 = 16'h1111; in2 = 16'h2222; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         // Competing requests while RUN must be dropped
         start = 1'b1; in1 = 16'($urandom); in2 = 16'($urandom); cin = 1'($urandom);
         tick(); lat++;
         start = 1'b0;
      end
      total++;
      if ({cout, sum} !== ref_sum(16'h1111, 16'h2222, 1'b1) || lat !== NSLICE) begin
         bad++;
         $display("FAIL ignore: got %b_%h lat=%0d want %h lat=%0d", cout, sum, lat,
                  ref_sum(16'h1111, 16'h2222, 1'b1), NSLICE);
      end
      tick();
   endtask

   task automatic test_reset_midrun();
      logic [W-1:0] s; logic co, o; int lat, bc;
      in1 = 16'hFFFF; in2 = 16'hFFFF; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      total++;
      if ({ready, busy, done, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL midrun reset: got rdy=%b busy=%b done=%b sum=%h cout=%b want 1 0 0 0000 0",
                  ready, busy, done, sum, cout);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      do_add(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, o, lat, bc);
      total++;
      if ({co, s} !== ref_sum(16'h1234, 16'h4321, 1'b0) || lat !== NSLICE) begin
         bad++;
         $display("FAIL after reset: got %b_%h lat=%0d want %h", co, s, lat,
                  ref_sum(16'h1234, 16'h4321, 1'b0));
      end
      tick();
   endtask

`ifdef RCA_SEQ_OVF_DETECT_EN
   task automatic test_ovf();
      logic [W-1:0] av[3] = '{16'h7FFF, 16'hFFFF, 16'h8000};
      logic [W-1:0] bv[3] = '{16'h0001, 16'h0001, 16'h8000};
      logic [W-1:0] s; logic co, o; int lat, bc;
      for (int i = 0; i < 3; i++) begin
         do_add(av[i], bv[i], 1'b0, 1'b0, s, co, o, lat, bc);
         total++;
         if (o !== ref_ovf(av[i], bv[i], 1'b0) || {co, s} !== ref_sum(av[i], bv[i], 1'b0)) begin
            bad++;
            $display("FAIL ovf%0d: got ovf=%b %b_%h want ovf=%b %h", i, o, co, s,
                     ref_ovf(av[i], bv[i], 1'b0), ref_sum(av[i], bv[i], 1'b0));
         end
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_ignore();
      test_reset_midrun();
`ifdef RCA_SEQ_OVF_DETECT_EN
      test_ovf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
